odd_even_sched: RTL

ODD_EVEN_SCHED -- requirements
Module: odd_even_sched

---
 rtl/odd_even_pkg.sv | 17 +
 rtl/odd_even_checker.sv | 14 +
 rtl/odd_even_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/odd_even_pkg.sv
// Shared types and constants for the odd/even scheduler and its checker.
package odd_even_pkg;

  localparam int unsigned NUM_W = 8;
  localparam int unsigned REQ_N = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic logic [REQ_N-1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/odd_even_checker.sv
// Combinational parity classifier: an operand is even when its LSB is clear.
module odd_even_checker
  import odd_even_pkg::*;
(
  input  logic [NUM_W-1:0] number,
  output logic             is_even
);

  logic unused_hi_s;

  assign is_even     = ~number[0];
  assign unused_hi_s = ^number[NUM_W-1:1];

endmodule

// File: rtl/odd_even_sched.sv
// Two-requester round-robin front end for a single shared odd/even checker.
// Optional statistics counters are compiled in with ODD_EVEN_SCHED_STATS_EN.
module odd_even_sched
  import odd_even_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REQ_N-1:0] req,
  input  logic [NUM_W-1:0] num0,
  input  logic [NUM_W-1:0] num1,
  output logic [REQ_N-1:0] ack,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [NUM_W-1:0] res_num,
  output logic             res_even,
  output logic             busy
`ifdef ODD_EVEN_SCHED_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] even_cnt,
  output logic [CNT_W-1:0] odd_cnt
`endif
);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             even_q, even_d;
  logic             valid_q, valid_d;
  logic [REQ_N-1:0] ack_s;
  logic             gnt_id_s;
  logic             chk_even_s;
  logic             hs_s;

  odd_even_checker u_checker (
    .number  (num_q),
    .is_even (chk_even_s)
  );

  // Round-robin pick: a lone requester wins, a tie goes to prio_q.
  always_comb begin
    gnt_id_s = 1'b0;
    case (req)
      2'b01:   gnt_id_s = 1'b0;
      2'b10:   gnt_id_s = 1'b1;
      2'b11:   gnt_id_s = prio_q;
      default: gnt_id_s = 1'b0;
    endcase
  end

  // Next-state and datapath update for the IDLE/CHECK/HOLD sequence.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    num_d   = num_q;
    even_d  = even_q;
    valid_d = valid_q;
    ack_s   = '0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          ack_s   = id_to_onehot(gnt_id_s);
          id_d    = gnt_id_s;
          num_d   = gnt_id_s ? num1 : num0;
          prio_d  = ~gnt_id_s;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        even_d  = chk_even_s;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Scheduler state and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      num_q   <= '0;
      even_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      num_q   <= num_d;
      even_q  <= even_d;
      valid_q <= valid_d;
    end
  end

  // ack is a Mealy pulse in IDLE, so it must be masked while reset is held.
  assign ack       = ack_s & {REQ_N{~reset}};
  assign res_valid = valid_q;
  assign res_id    = id_q;
  assign res_num   = num_q;
  assign res_even  = even_q;
  assign busy      = (state_q != IDLE);
  assign hs_s      = valid_q & res_ready;

`ifdef ODD_EVEN_SCHED_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] even_cnt_q, even_cnt_d;
  logic [CNT_W-1:0] odd_cnt_q, odd_cnt_d;

  // Saturating result counters; a clear overrides a same-cycle handshake.
  always_comb begin
    even_cnt_d = even_cnt_q;
    odd_cnt_d  = odd_cnt_q;
    if (stats_clr) begin
      even_cnt_d = '0;
      odd_cnt_d  = '0;
    end else if (hs_s && even_q && (even_cnt_q != CNT_MAX)) begin
      even_cnt_d = even_cnt_q + CNT_ONE;
    end else if (hs_s && !even_q && (odd_cnt_q != CNT_MAX)) begin
      odd_cnt_d = odd_cnt_q + CNT_ONE;
    end else begin
      even_cnt_d = even_cnt_q;
      odd_cnt_d  = odd_cnt_q;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      even_cnt_q <= '0;
      odd_cnt_q  <= '0;
    end else begin
      even_cnt_q <= even_cnt_d;
      odd_cnt_q  <= odd_cnt_d;
    end
  end

  assign even_cnt = even_cnt_q;
  assign odd_cnt  = odd_cnt_q;
`else
  localparam int unsigned unused_cnt_w = CNT_W;
  logic unused_hs_s;
  assign unused_hs_s = hs_s;
`endif

endmodule
